vector_ram_dp: RTL and testbench

//  Parametrised true dual-port block RAM for ASIC-tester vector storage.

---
 rtl/vector_ram_dp.sv | 185 ++++++++++++++++++
 tb/tb_vector_ram_dp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_ram_dp.sv
// True dual-port vector RAM with byte-lane writes, selectable write mode, post-reset clear
// sequencer and same-address collision flag. Define VECTOR_RAM_OUTREG_EN for a second output stage.
module vector_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BITS      = 13,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en_a,
    input  logic [DATA_WIDTH/8-1:0] i_we_a,
    input  logic [ADDR_BITS-1:0]    i_addr_a,
    input  logic [DATA_WIDTH-1:0]   i_din_a,
    output logic [DATA_WIDTH-1:0]   o_dout_a,
    output logic                    o_valid_a,
    input  logic                    i_en_b,
    input  logic [DATA_WIDTH/8-1:0] i_we_b,
    input  logic [ADDR_BITS-1:0]    i_addr_b,
    input  logic [DATA_WIDTH-1:0]   i_din_b,
    output logic [DATA_WIDTH-1:0]   o_dout_b,
    output logic                    o_valid_b,
    output logic                    o_busy,
    output logic                    o_collision
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] C_ONE       = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] C_TWO       = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] C_LAST_PAIR = ADDR_BITS'(DEPTH - 2);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]   r_clr_ptr, w_clr_ptr_nxt;
    logic                   w_busy;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_same, w_collision;
    logic [DATA_WIDTH-1:0]  w_old_a, w_old_b, w_new_a, w_new_b;
    logic                   w_ld_a, w_ld_b;
    logic [DATA_WIDTH-1:0]  w_dnx_a, w_dnx_b;

    logic [DATA_WIDTH-1:0]  r_dout_a, r_dout_b;
    logic                   r_valid_a, r_valid_b, r_coll;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_ptr_nxt = r_clr_ptr + C_TWO;
                if (r_clr_ptr == C_LAST_PAIR) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign o_busy  = w_busy;
    assign w_acc_a = i_en_a & ~w_busy & ~i_rst;
    assign w_acc_b = i_en_b & ~w_busy & ~i_rst;
    assign w_wr_a  = w_acc_a & (|i_we_a);
    assign w_wr_b  = w_acc_b & (|i_we_b);
    assign w_same  = (i_addr_a == i_addr_b);
    assign w_collision = w_acc_a & w_acc_b & w_same & (w_wr_a | w_wr_b);

    assign w_old_a = r_mem[i_addr_a];
    assign w_old_b = r_mem[i_addr_b];

    // Word as stored after this edge: B lanes first, A lanes on top so A wins shared lanes.
    always_comb begin
        w_new_a = w_old_a;
        w_new_b = w_old_b;
        for (int i = 0; i < NB; i++) begin
            if (w_wr_b && w_same && i_we_b[i]) w_new_a[i*8 +: 8] = i_din_b[i*8 +: 8];
            if (w_wr_a && i_we_a[i])           w_new_a[i*8 +: 8] = i_din_a[i*8 +: 8];
            if (w_wr_b && i_we_b[i])           w_new_b[i*8 +: 8] = i_din_b[i*8 +: 8];
            if (w_wr_a && w_same && i_we_a[i]) w_new_b[i*8 +: 8] = i_din_a[i*8 +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_busy && !i_rst) begin
            r_mem[r_clr_ptr]         <= '0;
            r_mem[r_clr_ptr + C_ONE] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_wr_b && i_we_b[i]) r_mem[i_addr_b][i*8 +: 8] <= i_din_b[i*8 +: 8];
                if (w_wr_a && i_we_a[i]) r_mem[i_addr_a][i*8 +: 8] <= i_din_a[i*8 +: 8];
            end
        end
    end

    // A reader always sees the pre-edge word, which also covers read/write collisions.
    always_comb begin
        w_ld_a  = 1'b0;
        w_dnx_a = w_old_a;
        w_ld_b  = 1'b0;
        w_dnx_b = w_old_b;
        if (w_acc_a) begin
            if (!w_wr_a || WRITE_MODE == 1) begin
                w_ld_a = 1'b1;
            end else if (WRITE_MODE == 0) begin
                w_ld_a  = 1'b1;
                w_dnx_a = w_new_a;
            end
        end
        if (w_acc_b) begin
            if (!w_wr_b || WRITE_MODE == 1) begin
                w_ld_b = 1'b1;
            end else if (WRITE_MODE == 0) begin
                w_ld_b  = 1'b1;
                w_dnx_b = w_new_b;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout_a  <= '0;
            r_dout_b  <= '0;
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
            r_coll    <= 1'b0;
        end else begin
            r_valid_a <= w_ld_a;
            r_valid_b <= w_ld_b;
            r_coll    <= w_collision;
            if (w_ld_a) r_dout_a <= w_dnx_a;
            if (w_ld_b) r_dout_b <= w_dnx_b;
        end
    end

`ifdef VECTOR_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_dout2_a, r_dout2_b;
    logic                  r_valid2_a, r_valid2_b, r_coll2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout2_a  <= '0;
            r_dout2_b  <= '0;
            r_valid2_a <= 1'b0;
            r_valid2_b <= 1'b0;
            r_coll2    <= 1'b0;
        end else begin
            r_valid2_a <= r_valid_a;
            r_valid2_b <= r_valid_b;
            r_coll2    <= r_coll;
            if (r_valid_a) r_dout2_a <= r_dout_a;
            if (r_valid_b) r_dout2_b <= r_dout_b;
        end
    end

    assign o_dout_a    = r_dout2_a;
    assign o_dout_b    = r_dout2_b;
    assign o_valid_a   = r_valid2_a;
    assign o_valid_b   = r_valid2_b;
    assign o_collision = r_coll2;
`else
    assign o_dout_a    = r_dout_a;
    assign o_dout_b    = r_dout_b;
    assign o_valid_a   = r_valid_a;
    assign o_valid_b   = r_valid_b;
    assign o_collision = r_coll;
`endif

endmodule

// File: tb/tb_vector_ram_dp.sv
// Bench for vector_ram_dp: three instances (one per write mode) share stimulus and are
// checked against a word-level reference model, a vector table and clear-sequence counts.
module tb_vector_ram_dp;

    localparam int DW    = 32;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
`ifdef VECTOR_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en_a, en_b;
    logic [3:0]    we_a, we_b;
    logic [AB-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] dout_a [3];
    logic [DW-1:0] dout_b [3];
    logic          valid_a [3];
    logic          valid_b [3];
    logic          busy [3];
    logic          coll [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vector_ram_dp #(
            .DATA_WIDTH(DW), .ADDR_BITS(AB), .WRITE_MODE(g), .CLEAR_ON_RESET(1)
        ) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
            .o_dout_a(dout_a[g]), .o_valid_a(valid_a[g]),
            .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
            .o_dout_b(dout_b[g]), .o_valid_b(valid_b[g]),
            .o_busy(busy[g]), .o_collision(coll[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: word array, remaining clear pairs, and per-mode output stages.
    logic [31:0] mem_m [DEPTH];
    int          clr_left = 0;
    logic [31:0] s1_da [3], s1_db [3], s2_da [3], s2_db [3];
    logic        s1_va [3], s1_vb [3], s2_va [3], s2_vb [3];
    logic        s1_c, s2_c;

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [3:0] we);
        logic [31:0] mask;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (w & ~mask) | (d & mask);
    endfunction

    task automatic port_model(input logic en, input logic [3:0] we, input logic [31:0] oldw,
                              input logic [31:0] neww, input int mode,
                              inout logic [31:0] d, output logic v);
        v = 1'b0;
        if (en) begin
            if (we == 4'h0)     begin d = oldw; v = 1'b1; end
            else if (mode == 0) begin d = neww; v = 1'b1; end
            else if (mode == 1) begin d = oldw; v = 1'b1; end
        end
    endtask

    task automatic model_edge();
        logic [31:0] oa, ob, na, nb;
        int base;
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                s1_da[m] = 0; s1_db[m] = 0; s2_da[m] = 0; s2_db[m] = 0;
                s1_va[m] = 0; s1_vb[m] = 0; s2_va[m] = 0; s2_vb[m] = 0;
            end
            s1_c = 0; s2_c = 0;
            clr_left = DEPTH / 2;
        end else begin
            for (int m = 0; m < 3; m++) begin
                if (s1_va[m]) s2_da[m] = s1_da[m];
                if (s1_vb[m]) s2_db[m] = s1_db[m];
                s2_va[m] = s1_va[m];
                s2_vb[m] = s1_vb[m];
            end
            s2_c = s1_c;
            if (clr_left > 0) begin
                base = DEPTH - 2 * clr_left;
                mem_m[base] = 0;
                mem_m[base + 1] = 0;
                clr_left--;
                for (int m = 0; m < 3; m++) begin s1_va[m] = 0; s1_vb[m] = 0; end
                s1_c = 0;
            end else begin
                oa = mem_m[addr_a];
                ob = mem_m[addr_b];
                if (en_b) mem_m[addr_b] = lane_merge(mem_m[addr_b], din_b, we_b);
                if (en_a) mem_m[addr_a] = lane_merge(mem_m[addr_a], din_a, we_a);
                na = mem_m[addr_a];
                nb = mem_m[addr_b];
                s1_c = en_a && en_b && (addr_a == addr_b) && (we_a != 0 || we_b != 0);
                for (int m = 0; m < 3; m++) begin
                    port_model(en_a, we_a, oa, na, m, s1_da[m], s1_va[m]);
                    port_model(en_b, we_b, ob, nb, m, s1_db[m], s1_vb[m]);
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("dout_a[%0d]", m), dout_a[m], (LAT == 2) ? s2_da[m] : s1_da[m]);
            chk($sformatf("dout_b[%0d]", m), dout_b[m], (LAT == 2) ? s2_db[m] : s1_db[m]);
            chk($sformatf("valid_a[%0d]", m), 32'(valid_a[m]), 32'((LAT == 2) ? s2_va[m] : s1_va[m]));
            chk($sformatf("valid_b[%0d]", m), 32'(valid_b[m]), 32'((LAT == 2) ? s2_vb[m] : s1_vb[m]));
            chk($sformatf("busy[%0d]", m), 32'(busy[m]), 32'(clr_left > 0));
            chk($sformatf("collision[%0d]", m), 32'(coll[m]), 32'((LAT == 2) ? s2_c : s1_c));
        end
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
    endtask

    task automatic wait_lat();
        idle();
        for (int k = 1; k < LAT; k++) step();
    endtask

    task automatic count_busy(input string nm);
        int n, guard;
        n = 0; guard = 0;
        idle();
        while (busy[0] && guard < 40) begin
            n++; guard++;
            step();
        end
        chk(nm, n, 8);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; we_a = 4'h0; addr_a = AB'(i);
            en_b = 1'b1; we_b = 4'h0; addr_b = AB'(DEPTH - 1 - i);
            step();
            wait_lat();
            chk($sformatf("%s_a@%0d", nm, i), dout_a[0], 32'h0);
            chk($sformatf("%s_b@%0d", nm, DEPTH - 1 - i), dout_b[0], 32'h0);
            chk($sformatf("%s_vb@%0d", nm, i), 32'(valid_b[0]), 32'h1);
        end
    endtask

    task automatic rand_inputs();
        en_a   = ($urandom_range(0, 3) != 0);
        we_a   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        addr_a = AB'($urandom_range(0, DEPTH - 1));
        din_a  = $urandom;
        en_b   = ($urandom_range(0, 3) != 0);
        we_b   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        addr_b = ($urandom_range(0, 2) == 0) ? addr_a : AB'($urandom_range(0, DEPTH - 1));
        din_b  = $urandom;
    endtask

    typedef struct {
        logic        en_a; logic [3:0] we_a; logic [3:0] ad_a; logic [31:0] di_a;
        logic        en_b; logic [3:0] we_b; logic [3:0] ad_b; logic [31:0] di_b;
        logic [31:0] xa0; logic va0; logic [31:0] xa1; logic va1; logic [31:0] xa2; logic va2;
        logic [31:0] xb;  logic vb;  logic xc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'hDE22BE44, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0,
                    32'hDE22BE44, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'hDE22BE44, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 4'd3, 32'hAAAAAAAA, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'hAAAAAAAA, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'hDE22BE44, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 4'd3, 32'h55555555, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'h55555555, 1'b1, 32'hAAAAAAAA, 1'b1, 32'h0, 1'b0, 32'hDE22BE44, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'h55555555, 1'b1, 32'h55555555, 1'b1, 32'h55555555, 1'b1, 32'hDE22BE44, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'h12345678, 1'b1, 32'h55555555, 1'b1, 32'h55555555, 1'b0, 32'hDE22BE44, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 4'd7, 32'h1, 1'b1, 4'hF, 4'd7, 32'h2,
                    32'h1, 1'b1, 32'h0, 1'b1, 32'h55555555, 1'b0, 32'h1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0,
                    32'h1, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 4'd9, 32'h10, 1'b0, 4'h0, 4'd0, 32'h0,
                    32'h10, 1'b1, 32'h0, 1'b1, 32'h1, 1'b0, 32'h1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 4'd9, 32'h20, 1'b1, 4'h0, 4'd9, 32'h0,
                    32'h20, 1'b1, 32'h10, 1'b1, 32'h1, 1'b0, 32'h10, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
                    32'h20, 1'b0, 32'h10, 1'b0, 32'h1, 1'b0, 32'h20, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'h3, 4'd7, 32'hAAAAAAAA, 1'b1, 4'h6, 4'd7, 32'hBBBBBBBB,
                    32'h00BBAAAA, 1'b1, 32'h1, 1'b1, 32'h1, 1'b0, 32'h00BBAAAA, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0,
                    32'h00BBAAAA, 1'b0, 32'h1, 1'b0, 32'h1, 1'b0, 32'h00BBAAAA, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h8, 4'd2, 32'hCAFEF00D,
                    32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'hCA000000, 1'b1, 1'b1};

        rst = 1'b1; idle(); addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        step();
        chk("reset_busy", 32'(busy[0]), 32'h1);
        chk("reset_dout_a", dout_a[0], 32'h0);
        chk("reset_valid_b", 32'(valid_b[0]), 32'h0);
        rst = 1'b0;
        count_busy("t1_busy_cycles");
        read_all_zero("t1_clear");

        for (int r = 0; r < 15; r++) begin
            en_a = tbl[r].en_a; we_a = tbl[r].we_a; addr_a = tbl[r].ad_a; din_a = tbl[r].di_a;
            en_b = tbl[r].en_b; we_b = tbl[r].we_b; addr_b = tbl[r].ad_b; din_b = tbl[r].di_b;
            step();
            if (LAT == 2) chk($sformatf("row%0d_vb_early", r), 32'(valid_b[0]), 32'h0);
            wait_lat();
            chk($sformatf("row%0d_dout_a0", r), dout_a[0], tbl[r].xa0);
            chk($sformatf("row%0d_valid_a0", r), 32'(valid_a[0]), 32'(tbl[r].va0));
            chk($sformatf("row%0d_dout_a1", r), dout_a[1], tbl[r].xa1);
            chk($sformatf("row%0d_valid_a1", r), 32'(valid_a[1]), 32'(tbl[r].va1));
            chk($sformatf("row%0d_dout_a2", r), dout_a[2], tbl[r].xa2);
            chk($sformatf("row%0d_valid_a2", r), 32'(valid_a[2]), 32'(tbl[r].va2));
            chk($sformatf("row%0d_dout_b", r), dout_b[0], tbl[r].xb);
            chk($sformatf("row%0d_valid_b", r), 32'(valid_b[0]), 32'(tbl[r].vb));
            chk($sformatf("row%0d_collision", r), 32'(coll[0]), 32'(tbl[r].xc));
        end
        idle();
        step();
        chk("collision_one_cycle", 32'(coll[0]), 32'h0);

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        rst = 1'b1; idle();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
        end
        rand_inputs();
        rst = 1'b1;
        step();
        chk("t6_busy_held", 32'(busy[0]), 32'h1);
        rst = 1'b0;
        count_busy("t6_busy_cycles");
        read_all_zero("t6_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
